// File: rtl/tank_pkg.sv
// Shared tank/projectile types, screen limits and the trig-to-velocity helper.
package tank_pkg;

    typedef logic [9:0]        coord_t;
    typedef logic signed [7:0] vel_t;
    typedef logic [7:0]        trig_t;

    localparam coord_t X_MAX = 10'd639;
    localparam coord_t Y_MAX = 10'd479;

    // trig is sign-magnitude Q0.7; the magnitude is (step * |trig|) >> 7.
    function automatic vel_t trig_to_vel(input logic [6:0] step, input trig_t trig);
        logic [13:0] prod;
        vel_t        mag;
        prod = 14'(step) * 14'(trig[6:0]);
        mag  = vel_t'({1'b0, prod[13:7]});
        return trig[7] ? -mag : mag;
    endfunction

endpackage

// File: rtl/bullet_pool_if.sv
// Tank-controller / collision-logic side of the bullet pool.
interface bullet_pool_if #(
    parameter int N_BULLETS = 4
);
    import tank_pkg::*;

    logic                             fire;
    coord_t                           tankX;
    coord_t                           tankY;
    trig_t                            sin;
    trig_t                            cos;
    logic [N_BULLETS-1:0]             wallTop;
    logic [N_BULLETS-1:0]             wallBottom;
    logic [N_BULLETS-1:0]             wallLeft;
    logic [N_BULLETS-1:0]             wallRight;
    logic [N_BULLETS-1:0]             kill;
    logic [N_BULLETS-1:0]             active;
    logic [10*N_BULLETS-1:0]          BulletX;
    logic [10*N_BULLETS-1:0]          BulletY;
    logic [$clog2(N_BULLETS+1)-1:0]   active_count;
    logic                             shot_fired;
    logic                             shot_dropped;

    modport master (
        output fire, tankX, tankY, sin, cos,
        output wallTop, wallBottom, wallLeft, wallRight, kill,
        input  active, BulletX, BulletY, active_count, shot_fired, shot_dropped
    );

    modport slave (
        input  fire, tankX, tankY, sin, cos,
        input  wallTop, wallBottom, wallLeft, wallRight, kill,
        output active, BulletX, BulletY, active_count, shot_fired, shot_dropped
    );

endinterface

// File: rtl/bullet_slot.sv
// One projectile slot: position, velocity, age, bounce count and retirement.
module bullet_slot
    import tank_pkg::*;
#(
    parameter int LIFETIME   = 1000,
    parameter int MAX_BOUNCE = 5
) (
    input  logic   frame_clk,
    input  logic   Reset,
    input  logic   i_load,
    input  coord_t i_init_x,
    input  coord_t i_init_y,
    input  vel_t   i_init_vx,
    input  vel_t   i_init_vy,
    input  logic   i_wall_tb,
    input  logic   i_wall_lr,
    input  logic   i_kill,
    output logic   o_active,
    output coord_t o_x,
    output coord_t o_y
);

    localparam int TIMER_W  = (LIFETIME > 1) ? $clog2(LIFETIME) : 1;
    localparam int BOUNCE_W = $clog2(MAX_BOUNCE + 1) + 1;

    logic                r_active;
    coord_t              r_x;
    coord_t              r_y;
    vel_t                r_vx;
    vel_t                r_vy;
    logic [TIMER_W-1:0]  r_timer;
    logic [BOUNCE_W-1:0] r_bounce;

    vel_t   w_vx_new;
    vel_t   w_vy_new;
    logic   w_wall;
    logic   w_retire;

    assign w_wall   = i_wall_tb | i_wall_lr;
    assign w_vx_new = i_wall_lr ? -r_vx : r_vx;
    assign w_vy_new = i_wall_tb ? -r_vy : r_vy;
    assign w_retire = i_kill
                    | (r_timer == TIMER_W'(LIFETIME - 1))
                    | (w_wall && (r_bounce == BOUNCE_W'(MAX_BOUNCE)));

    always_ff @(posedge frame_clk) begin
        if (!Reset) begin
            r_active <= 1'b0;
            r_x      <= '0;
            r_y      <= '0;
            r_vx     <= '0;
            r_vy     <= '0;
            r_timer  <= '0;
            r_bounce <= '0;
        end else if (i_load) begin
            r_active <= 1'b1;
            r_x      <= i_init_x;
            r_y      <= i_init_y;
            r_vx     <= i_init_vx;
            r_vy     <= i_init_vy;
            r_timer  <= '0;
            r_bounce <= '0;
        end else if (r_active) begin
            // A retiring slot freezes where it is; motion only happens while it survives.
            if (w_retire) begin
                r_active <= 1'b0;
            end else begin
                r_vx    <= w_vx_new;
                r_vy    <= w_vy_new;
                r_x     <= r_x + {{2{w_vx_new[7]}}, w_vx_new};
                r_y     <= r_y + {{2{w_vy_new[7]}}, w_vy_new};
                r_timer <= r_timer + TIMER_W'(1);
                if (w_wall) r_bounce <= r_bounce + BOUNCE_W'(1);
            end
        end
    end

    assign o_active = r_active;
    assign o_x      = r_x;
    assign o_y      = r_y;

endmodule

// File: rtl/bullet_pool.sv
// Per-tank projectile pool: fire edge detect, cooldown, lowest-free allocation and N slots.
module bullet_pool
    import tank_pkg::*;
#(
    parameter int N_BULLETS  = 4,
    parameter int STEP       = 32,
    parameter int LIFETIME   = 1000,
    parameter int MAX_BOUNCE = 5,
    parameter int COOLDOWN   = 15,
    parameter int SPAWN_MULT = 2
) (
    input  logic         frame_clk,
    input  logic         Reset,
    bullet_pool_if.slave bus
);

    localparam int CNT_W = $clog2(N_BULLETS + 1);
    localparam int CD_W  = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

    logic                 r_fire_q;
    logic [CD_W-1:0]      r_cooldown;
    logic                 r_shot_fired;
    logic                 r_shot_dropped;
    logic [CNT_W-1:0]     r_active_count;

    logic                 w_fire_edge;
    logic                 w_take;
    logic                 w_alloc;
    logic                 w_drop;
    logic [N_BULLETS-1:0] w_active;
    logic [N_BULLETS-1:0] w_free;
    logic [N_BULLETS-1:0] w_lowest;
    logic [N_BULLETS-1:0] w_load;
    logic [CNT_W-1:0]     w_popcount;
    vel_t                 w_vx;
    vel_t                 w_vy;
    coord_t               w_spawn_x;
    coord_t               w_spawn_y;
    coord_t               w_x [N_BULLETS];
    coord_t               w_y [N_BULLETS];

    assign w_fire_edge = bus.fire & ~r_fire_q;
    assign w_take      = w_fire_edge && (r_cooldown == '0);
    assign w_free      = ~w_active;
    assign w_lowest    = w_free & (-w_free);
    assign w_alloc     = w_take & (|w_free);
    assign w_drop      = w_take & ~(|w_free);
    assign w_load      = w_alloc ? w_lowest : '0;

    // Screen Y grows downward, so a positive sine means moving toward smaller Y.
    assign w_vx      = trig_to_vel(7'(STEP), bus.cos);
    assign w_vy      = -trig_to_vel(7'(STEP), bus.sin);
    assign w_spawn_x = bus.tankX + coord_t'({{2{w_vx[7]}}, w_vx} * coord_t'(SPAWN_MULT));
    assign w_spawn_y = bus.tankY + coord_t'({{2{w_vy[7]}}, w_vy} * coord_t'(SPAWN_MULT));

    for (genvar i = 0; i < N_BULLETS; i++) begin : gen_slot
        bullet_slot #(
            .LIFETIME   (LIFETIME),
            .MAX_BOUNCE (MAX_BOUNCE)
        ) u_slot (
            .frame_clk  (frame_clk),
            .Reset      (Reset),
            .i_load     (w_load[i]),
            .i_init_x   (w_spawn_x),
            .i_init_y   (w_spawn_y),
            .i_init_vx  (w_vx),
            .i_init_vy  (w_vy),
            .i_wall_tb  (bus.wallTop[i] | bus.wallBottom[i]),
            .i_wall_lr  (bus.wallLeft[i] | bus.wallRight[i]),
            .i_kill     (bus.kill[i]),
            .o_active   (w_active[i]),
            .o_x        (w_x[i]),
            .o_y        (w_y[i])
        );
    end

    always_comb begin
        w_popcount = '0;
        for (int i = 0; i < N_BULLETS; i++) begin
            w_popcount = w_popcount + CNT_W'(w_active[i]);
        end
    end

    always_ff @(posedge frame_clk) begin
        if (!Reset) begin
            r_fire_q       <= 1'b0;
            r_cooldown     <= '0;
            r_shot_fired   <= 1'b0;
            r_shot_dropped <= 1'b0;
            r_active_count <= '0;
        end else begin
            r_fire_q       <= bus.fire;
            r_shot_fired   <= w_alloc;
            r_shot_dropped <= w_drop;
            r_active_count <= w_popcount;
            if (w_alloc) begin
                r_cooldown <= CD_W'(COOLDOWN);
            end else if (r_cooldown != '0) begin
                r_cooldown <= r_cooldown - CD_W'(1);
            end
        end
    end

    always_comb begin
        bus.BulletX = '0;
        bus.BulletY = '0;
        for (int i = 0; i < N_BULLETS; i++) begin
            bus.BulletX[10*i +: 10] = w_x[i];
            bus.BulletY[10*i +: 10] = w_y[i];
        end
    end

    assign bus.active       = w_active;
    assign bus.active_count = r_active_count;
    assign bus.shot_fired   = r_shot_fired;
    assign bus.shot_dropped = r_shot_dropped;

endmodule
